// File: rtl/snn_pkg.sv
// Shared types and default widths for the spiking-network readout logic.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ARGMAX = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int SNN_CNT_W = 8;
  localparam int SNN_WIN_W = 8;

  // Index range 0..n inclusive; the argmax scan uses index n as its finish cycle.
  function automatic int scan_idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spike_counter_sat.sv
// Saturating per-neuron spike counter; sat is high while the count sits at full scale.
module spike_counter_sat
  import snn_pkg::*;
#(
  parameter int CNT_W = SNN_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  assign sat = (count == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/snn_spike_readout.sv
// Spike-count window and sequential argmax readout for the network's output layer.
// Optional membrane snapshot port pair enabled by SNN_READOUT_MEMBRANE_SNAPSHOT_EN.
//
// state  | meaning
// IDLE   | waiting for start; previous result held on outputs
// COUNT  | accumulating spikes on enable steps until window_len samples taken
// ARGMAX | scanning one neuron per cycle, plus one finish cycle
// HOLD   | result presented with out_valid until out_ready
module snn_spike_readout
  import snn_pkg::*;
#(
  parameter int N     = 2,
  parameter int CNT_W = SNN_CNT_W,
  parameter int WIN_W = SNN_WIN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [N-1:0]         spikes_in,
  input  logic [WIN_W-1:0]     window_len,
  input  logic                 start,
  input  logic                 out_ready,
`ifdef SNN_READOUT_MEMBRANE_SNAPSHOT_EN
  input  logic [N*8-1:0]       membrane_in,
  output logic [N*8-1:0]       membrane_snap,
`endif
  output logic                 busy,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] winner,
  output logic [CNT_W-1:0]     winner_count,
  output logic                 tie,
  output logic                 overflow,
  output logic [N*CNT_W-1:0]   counts
);

  localparam int WI_W  = $clog2(N);
  localparam int IDX_W = scan_idx_w(N);

  state_t           state;
  logic [WIN_W-1:0] len_q;
  logic [WIN_W-1:0] step;
  logic [IDX_W-1:0] idx;

  logic             clear;
  logic             sample;
  logic             last_sample;
  logic             ovf_hit;
  logic [N-1:0]     inc;
  logic [N-1:0]     sat;
  logic [CNT_W-1:0] cnt [N];
  logic [CNT_W-1:0] cur_cnt;

  assign clear       = (state == IDLE) && start;
  assign sample      = (state == COUNT) && enable;
  assign last_sample = sample && (step == (len_q - WIN_W'(1)));
  assign ovf_hit     = |(inc & sat);

  for (genvar g = 0; g < N; g++) begin : g_cnt
    assign inc[g] = sample && spikes_in[g];

    spike_counter_sat #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(clear),
      .inc  (inc[g]),
      .count(cnt[g]),
      .sat  (sat[g])
    );

    assign counts[g*CNT_W +: CNT_W] = cnt[g];
  end

  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) cur_cnt = cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      len_q        <= '0;
      step         <= '0;
      idx          <= '0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      winner       <= '0;
      winner_count <= '0;
      tie          <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q        <= (window_len == '0) ? WIN_W'(1) : window_len;
            step         <= '0;
            overflow     <= 1'b0;
            tie          <= 1'b0;
            winner       <= '0;
            winner_count <= '0;
            busy         <= 1'b1;
            state        <= COUNT;
          end
        end
        COUNT: begin
          if (sample) begin
            overflow <= overflow | ovf_hit;
            if (last_sample) begin
              idx   <= '0;
              state <= ARGMAX;
            end else begin
              step <= step + WIN_W'(1);
            end
          end
        end
        ARGMAX: begin
          if (idx == IDX_W'(N)) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            // Ties keep the earlier (lower) index because only strictly greater replaces.
            if (cur_cnt > winner_count) begin
              winner       <= WI_W'(idx);
              winner_count <= cur_cnt;
              tie          <= 1'b0;
            end else if (cur_cnt == winner_count) begin
              tie <= 1'b1;
            end
            idx <= idx + IDX_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SNN_READOUT_MEMBRANE_SNAPSHOT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      membrane_snap <= '0;
    end else if (last_sample) begin
      membrane_snap <= membrane_in;
    end
  end
`endif

endmodule

// File: tb/tb_snn_spike_readout.sv
// Scoreboard bench for snn_spike_readout: directed windows with hand-computed results.
module tb_snn_spike_readout;

  localparam int N     = 2;
  localparam int CNT_W = 3;
  localparam int WIN_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic [N-1:0]       spikes_in;
  logic [WIN_W-1:0]   window_len;
  logic               start;
  logic               out_ready;
  logic               busy;
  logic               out_valid;
  logic [0:0]         winner;
  logic [CNT_W-1:0]   winner_count;
  logic               tie;
  logic               overflow;
  logic [N*CNT_W-1:0] counts;

  snn_spike_readout #(
    .N    (N),
    .CNT_W(CNT_W),
    .WIN_W(WIN_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .spikes_in   (spikes_in),
    .window_len  (window_len),
    .start       (start),
    .out_ready   (out_ready),
    .busy        (busy),
    .out_valid   (out_valid),
    .winner      (winner),
    .winner_count(winner_count),
    .tie         (tie),
    .overflow    (overflow),
    .counts      (counts)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:0]         w;
    logic [CNT_W-1:0]   wc;
    logic               t;
    logic               o;
    logic [N*CNT_W-1:0] c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   busy_cnt = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (out_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got a result expected none");
      end else begin
        mon_e = sb.pop_front();
        check("winner", 32'(winner), 32'(mon_e.w));
        check("winner_count", 32'(winner_count), 32'(mon_e.wc));
        check("tie", 32'(tie), 32'(mon_e.t));
        check("overflow", 32'(overflow), 32'(mon_e.o));
        check("counts", 32'(counts), 32'(mon_e.c));
      end
    end
    prev_valid = out_valid;
  end

  task automatic push_exp(input logic w, input logic [CNT_W-1:0] wc, input logic t,
                          input logic o, input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1);
    exp_t e;
    e.w  = w;
    e.wc = wc;
    e.t  = t;
    e.o  = o;
    e.c  = {c1, c0};
    sb.push_back(e);
  endtask

  task automatic start_win(input logic [WIN_W-1:0] len);
    @(negedge clk);
    busy_cnt   = 0;
    start      = 1'b1;
    window_len = len;
    enable     = 1'b0;
    spikes_in  = '0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic step(input logic en, input logic [N-1:0] sp);
    enable    = en;
    spikes_in = sp;
    @(negedge clk);
  endtask

  task automatic wait_valid(output int c);
    enable    = 1'b0;
    spikes_in = '0;
    c = 0;
    while (!out_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL result_timeout: got no out_valid after %0d cycles expected 3", c);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_counts"}, 32'(counts), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_winner"}, 32'(winner), 32'd0);
    check({tag, "_wcount"}, 32'(winner_count), 32'd0);
    check({tag, "_tie"}, 32'(tie), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int c;
    rst_n      = 1'b0;
    enable     = 1'b0;
    spikes_in  = '0;
    window_len = '0;
    start      = 1'b0;
    out_ready  = 1'b1;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Neuron 0 fires every step of a 4-step window.
    push_exp(1'b0, 3'd4, 1'b0, 1'b0, 3'd4, 3'd0);
    start_win(8'd4);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01);
    wait_valid(c);
    check("t1_latency", 32'(c), 32'd3);
    check("t1_busy_cycles", 32'(busy_cnt), 32'd7);
    @(negedge clk);
    check("t1_idle_valid", 32'(out_valid), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_hold_counts", 32'(counts), 32'h4);
    check("t1_hold_wcount", 32'(winner_count), 32'd4);

    // Equal counts: lower index wins, tie flagged.
    push_exp(1'b0, 3'd2, 1'b1, 1'b0, 3'd2, 3'd2);
    start_win(8'd3);
    step(1'b1, 2'b11);
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    wait_valid(c);
    @(negedge clk);

    // Eight attempts on a 3-bit counter: saturates at 7 and flags overflow.
    push_exp(1'b1, 3'd7, 1'b0, 1'b1, 3'd0, 3'd7);
    start_win(8'd8);
    for (int i = 0; i < 8; i++) step(1'b1, 2'b10);
    wait_valid(c);
    @(negedge clk);
    check("t3_idle_ovf_held", 32'(overflow), 32'd1);

    // Exactly reaching full scale is not an overflow.
    push_exp(1'b1, 3'd7, 1'b0, 1'b0, 3'd0, 3'd7);
    start_win(8'd7);
    for (int i = 0; i < 7; i++) step(1'b1, 2'b10);
    wait_valid(c);
    @(negedge clk);

    // Disabled steps are skipped: four COUNT cycles for a 2-sample window.
    push_exp(1'b1, 3'd2, 1'b0, 1'b0, 3'd1, 3'd2);
    start_win(8'd2);
    step(1'b1, 2'b11);
    step(1'b0, 2'b11);
    step(1'b0, 2'b01);
    step(1'b1, 2'b10);
    wait_valid(c);
    check("t4_latency", 32'(c), 32'd3);
    check("t4_busy_cycles", 32'(busy_cnt), 32'd7);
    @(negedge clk);

    // window_len of zero runs a single-sample window.
    push_exp(1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 3'd1);
    start_win(8'd0);
    step(1'b1, 2'b10);
    wait_valid(c);
    check("t5_latency", 32'(c), 32'd3);
    check("t5_busy_cycles", 32'(busy_cnt), 32'd4);
    @(negedge clk);

    // No spikes at all.
    push_exp(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 3'd0);
    start_win(8'd2);
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    wait_valid(c);
    @(negedge clk);

    // Back-pressure in HOLD; start during COUNT and HOLD must be ignored.
    out_ready = 1'b0;
    push_exp(1'b0, 3'd2, 1'b0, 1'b0, 3'd2, 3'd1);
    start_win(8'd2);
    start = 1'b1;
    step(1'b1, 2'b11);
    start = 1'b0;
    step(1'b1, 2'b01);
    wait_valid(c);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      @(negedge clk);
      check("t7_stall_valid", 32'(out_valid), 32'd1);
      check("t7_stall_wcount", 32'(winner_count), 32'd2);
      check("t7_stall_counts", 32'(counts), 32'(6'b001010));
    end
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t7_release_valid", 32'(out_valid), 32'd0);
    check("t7_release_busy", 32'(busy), 32'd0);

    // Reset mid-window discards everything; the next window runs cleanly.
    start_win(8'd5);
    step(1'b1, 2'b11);
    step(1'b1, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(1'b0, 3'd1, 1'b1, 1'b0, 3'd1, 3'd1);
    start_win(8'd1);
    step(1'b1, 2'b11);
    wait_valid(c);
    check("t8_latency", 32'(c), 32'd3);
    @(negedge clk);
    @(negedge clk);

    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snn_spike_readout.md
# snn_spike_readout

Output-side decoder for the two-layer spiking network: counts output spikes per second-layer neuron over a programmable window of network time steps, then performs a sequential argmax and presents the winning class, its count and all per-neuron counts through a valid/ready handshake. Sits directly downstream of the network's `output_spikes`, sharing its clock and `enable` step strobe, and feeds the host/readout interface.

## Interface
Parameters:
- `N`, 2, number of output neurons (classes); ≥2
- `CNT_W`, 8, width of each per-neuron spike counter
- `WIN_W`, 8, width of the window-length field

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous reset, active-low
- `enable`  in  1  network step strobe; spikes sampled only when high
- `spikes_in`  in  N  output spikes of the network's second layer
- `window_len`  in  WIN_W  steps per window; sampled at `start`
- `start`  in  1  begin a window (accepted only in IDLE)
- `out_ready`  in  1  consumer accepts result
- `busy`  out  1  high in COUNT and ARGMAX
- `out_valid`  out  1  result valid (HOLD)
- `winner`  out  $clog2(N)  index of max-count neuron
- `winner_count`  out  CNT_W  count of winner
- `tie`  out  1  another neuron equals winner's count
- `overflow`  out  1  any counter saturated this window
- `counts`  out  N*CNT_W  per-neuron counts, neuron i at [i*CNT_W +: CNT_W]

## Operation
- States: IDLE, COUNT, ARGMAX, HOLD.
- IDLE: `start`=1 → clear counters, `overflow`, `tie`; latch `window_len` (0 treated as 1); step counter=0; → COUNT.
- COUNT: each cycle with `enable`=1, counter i increments for each set `spikes_in[i]`; step counter increments. On the enable cycle where step==len-1 → ARGMAX, idx=0. `enable`=0 cycles are ignored. `start` ignored.
- Counters saturate at 2^CNT_W−1; attempted increment at saturation sets sticky `overflow`.
- ARGMAX: one neuron per cycle, idx 0..N−1. Strictly greater replaces winner and clears `tie`; equal sets `tie`, keeps lower index. After idx N−1 → HOLD.
- HOLD: `out_valid`=1, outputs stable. `out_valid`&&`out_ready` → IDLE; `start` in that same cycle is ignored (must be reissued in IDLE).
- All counts zero → `winner`=0, `winner_count`=0, `tie`=1.
- `counts`, `winner`, `winner_count`, `tie`, `overflow` hold their values in IDLE until next `start`.

## Timing
- Reset (async assert, sync deassert upstream): state IDLE; all outputs 0, counters 0.
- `start` sampled at edge k → COUNT from edge k; first spike sample at edge k+1 if `enable`=1.
- Last sample at edge m → ARGMAX at m; `out_valid` rises at edge m+N+1.
- Minimum window-to-result: window_len enable cycles + N + 1 cycles; `out_ready` held high yields IDLE one cycle after `out_valid`.
- `rst_n` low mid-window/mid-scan/in HOLD: immediate return to IDLE, result discarded.

## Configuration
- `SNN_READOUT_MEMBRANE_SNAPSHOT_EN` defined: adds `membrane_in` (in, N*8, network debug membrane potentials of layer 2) and `membrane_snap` (out, N*8); `membrane_in` captured on the last COUNT sample edge, held through HOLD and IDLE, reset to 0.
- Undefined: neither port exists; no snapshot registers.

## Structure
- Shared package `snn_pkg`: state enum (IDLE/COUNT/ARGMAX/HOLD), default widths `SNN_CNT_W`, `SNN_WIN_W`.
- One sub-module: `spike_counter_sat` (clear, inc, saturating CNT_W counter with sat flag), instantiated N times.

## Test plan
- N=2, window_len=4, spikes_in=2'b01 every enable → counts {0,4}, winner=0, winner_count=4, tie=0, out_valid at last-sample+3.
- window_len=3, neuron0 spikes 2×, neuron1 2× → winner=0, tie=1.
- CNT_W=2, window_len=6, neuron1 always spikes → count 3, overflow=1, winner=1.
- `enable` toggled 1/0, window_len=2 → only enable-high cycles counted; busy spans 4 COUNT cycles; window_len=0 behaves as 1.
- `out_ready`=0 for 5 cycles in HOLD → outputs stable; `start` during HOLD/COUNT ignored.
- `rst_n` pulsed low mid-COUNT → all outputs 0, IDLE; next `start` runs cleanly.
